// File: rtl/dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dac_serializer
// Purpose  : Rounds and saturates signed filter samples to OUT_W bits, queues
//            them in a FIFO and shifts each out MSB-first on a 3-wire DAC bus.
// Revision : 1.0 - initial release
// ============================================================================
module dac_serializer #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT   = 7,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          y_in,
  input  logic                     y_valid,
  output logic                     in_ready,
  output logic                     dac_sclk,
  output logic                     dac_sdata,
  output logic                     dac_cs_n,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              ovf_count,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(OUT_W);

  localparam logic [AW:0]             C_FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0]           C_HALF     = DW'(CLK_DIV);
  localparam logic [DW-1:0]           C_DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [GW-1:0]           C_GAP_LAST = GW'(CLK_DIV - 1);
  localparam logic [BW-1:0]           C_BIT_LAST = BW'(OUT_W - 1);
  localparam logic [IN_W:0]           C_RND      = (IN_W + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [IN_W:0]    C_QMAX     = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [IN_W:0]    C_QMIN     = -((IN_W + 1)'(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0]        C_SAT_POS  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]        C_SAT_NEG  = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Quantiser: round half-up by adding 2^(SHIFT-1), arithmetic shift, clamp.
  // One extra bit of headroom keeps the rounding add from overflowing.
  // ---------------------------------------------------------------------------
  logic [IN_W:0]        q_sum;
  logic signed [IN_W:0] q_full;
  logic [OUT_W-1:0]     q_sat;
  logic                 q_ovf;

  assign q_sum  = {y_in[IN_W-1], y_in} + C_RND;
  assign q_full = $signed(q_sum) >>> SHIFT;

  // Clamp the shifted value into the signed output range.
  always_comb begin
    q_sat = q_full[OUT_W-1:0];
    q_ovf = 1'b0;
    if (q_full > C_QMAX) begin
      q_sat = C_SAT_POS;
      q_ovf = 1'b1;
    end else if (q_full < C_QMIN) begin
      q_sat = C_SAT_NEG;
      q_ovf = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] head;
  state_t           state;

  assign in_ready = (fifo_level != C_FULL_LVL);
  assign push     = y_valid && in_ready;
  assign pop      = (state == ST_IDLE) && (fifo_level != '0);
  assign head     = mem[rd_ptr];

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= q_sat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
    end
  end

  // Sticky event counters: saturation on accepted samples, drops when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push && q_ovf && (ovf_count != 16'hFFFF)) begin
        ovf_count <= ovf_count + 1'b1;
      end
      if (y_valid && !in_ready && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    div_cnt;
  logic [DW-1:0]    div_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [OUT_W-1:0] shreg;

  assign div_nxt = div_cnt + 1'b1;

  // Frame sequencing; sclk is registered so it tracks div_cnt exactly and
  // data changes coincide with the sclk falling edge at each bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dac_sclk  <= 1'b0;
      dac_sdata <= 1'b0;
      dac_cs_n  <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dac_sclk <= 1'b0;
          dac_cs_n <= 1'b1;
          if (fifo_level != '0) begin
            shreg     <= head;
            dac_sdata <= head[OUT_W-1];
            dac_cs_n  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == C_DIV_LAST) begin
            div_cnt  <= '0;
            dac_sclk <= 1'b0;
            if (bit_cnt == C_BIT_LAST) begin
              dac_cs_n  <= 1'b1;
              dac_sdata <= 1'b0;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shreg     <= {shreg[OUT_W-2:0], 1'b0};
              dac_sdata <= shreg[OUT_W-2];
            end
          end else begin
            div_cnt  <= div_nxt;
            dac_sclk <= (div_nxt >= C_HALF);
          end
        end
        ST_GAP: begin
          if (gap_cnt == C_GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          dac_cs_n <= 1'b1;
          dac_sclk <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_serializer
// Purpose  : Self-checking bench for dac_serializer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dac_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] y_in = '0;
  logic        y_valid = 1'b0;
  logic        in_ready, dac_sclk, dac_sdata, dac_cs_n;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_count;
  logic [7:0]  drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dac_serializer dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .in_ready(in_ready),
    .dac_sclk(dac_sclk), .dac_sdata(dac_sdata), .dac_cs_n(dac_cs_n),
    .fifo_level(fifo_level), .ovf_count(ovf_count), .drop_count(drop_count)
  );

  // Serial bus monitor: reassembles frames from sclk rising edges.
  int         cycle = 0;
  int         cs_low_total = 0;
  logic [7:0] f_data[$];
  int         f_edges[$], f_low[$], f_start[$], f_end[$];

  initial begin
    logic       prev_sclk, prev_cs;
    logic [7:0] cur_bits;
    int         cur_edges, cur_low, cur_start;
    prev_sclk = 1'b0; prev_cs = 1'b1;
    cur_bits = '0; cur_edges = 0; cur_low = 0; cur_start = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!dac_cs_n && prev_cs) begin
        cur_bits = '0; cur_edges = 0; cur_low = 0; cur_start = cycle;
      end
      if (!dac_cs_n) begin
        cur_low++;
        cs_low_total++;
        if (dac_sclk && !prev_sclk) begin
          cur_bits = {cur_bits[6:0], dac_sdata};
          cur_edges++;
        end
      end
      if (dac_cs_n && !prev_cs) begin
        f_data.push_back(cur_bits);
        f_edges.push_back(cur_edges);
        f_low.push_back(cur_low);
        f_start.push_back(cur_start);
        f_end.push_back(cycle);
      end
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
    end
  end

  // Reference model state.
  logic [7:0] exp_q[$];
  int         exp_ovf, exp_drop;

  // Quantiser model: round(y / 128) half-up, clamp to [-128, 127]. Bit 8 = saturated.
  function automatic logic [8:0] model_q(input logic [15:0] y);
    int v, q;
    v = int'($signed(y));
    q = v + 64;
    q = (q >= 0) ? (q / 128) : -((-q + 127) / 128);
    if (q > 127)  return {1'b1, 8'h7F};
    if (q < -128) return {1'b1, 8'h80};
    return {1'b0, q[7:0]};
  endfunction

  task automatic clear_model();
    exp_q.delete(); exp_ovf = 0; exp_drop = 0;
    f_data.delete(); f_edges.delete(); f_low.delete(); f_start.delete(); f_end.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; y_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // Offer one sample at the current negedge; the model follows the handshake.
  task automatic offer(input logic [15:0] v);
    logic [8:0] m;
    m = model_q(v);
    y_in = v; y_valid = 1'b1;
    if (in_ready) begin
      exp_q.push_back(m[7:0]);
      if (m[8]) exp_ovf++;
    end else begin
      exp_drop++;
    end
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (f_data.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (f_data.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL wait_frames: got %0d frames, need %0d", f_data.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; y_valid = 1'b1; y_in = 16'h1234;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
    vectors++; if (dac_cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n: got %b need 1", dac_cs_n); end
    vectors++; if (dac_sclk !== 1'b0) begin miscompares++; $display("FAIL rst_sclk: got %b need 0", dac_sclk); end
    vectors++; if (dac_sdata !== 1'b0) begin miscompares++; $display("FAIL rst_sdata: got %b need 0", dac_sdata); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL rst_level: got %0d need 0", fifo_level); end
    vectors++; if (ovf_count !== 16'd0) begin miscompares++; $display("FAIL rst_ovf: got %0d need 0", ovf_count); end
    vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL rst_drop: got %0d need 0", drop_count); end
    rst = 1'b0; y_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL rst_no_push: level %0d need 0", fifo_level); end
    vectors++; if (dac_cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_idle_cs: got %b need 1", dac_cs_n); end
  endtask

  task automatic test_rounding();
    logic [7:0] want[3];
    want = '{8'h24, 8'h00, 8'hFF};
    do_reset();
    offer(16'h1234); offer(16'hFFC0); offer(16'hFFBF);
    wait_frames(3, 400);
    for (int i = 0; i < 3 && i < f_data.size(); i++) begin
      vectors++; if (f_data[i] !== want[i]) begin miscompares++; $display("FAIL round_data[%0d]: got %h need %h", i, f_data[i], want[i]); end
      vectors++; if (f_edges[i] != 8) begin miscompares++; $display("FAIL round_edges[%0d]: got %0d need 8", i, f_edges[i]); end
      vectors++; if (f_low[i] != 64) begin miscompares++; $display("FAIL round_cs_low[%0d]: got %0d need 64", i, f_low[i]); end
    end
    vectors++; if (ovf_count !== 16'd0) begin miscompares++; $display("FAIL round_ovf: got %0d need 0", ovf_count); end
  endtask

  task automatic test_saturation();
    logic [7:0] want[2];
    want = '{8'h7F, 8'h80};
    do_reset();
    offer(16'h7FFF); offer(16'h8000);
    wait_frames(2, 300);
    for (int i = 0; i < 2 && i < f_data.size(); i++) begin
      vectors++; if (f_data[i] !== want[i]) begin miscompares++; $display("FAIL sat_data[%0d]: got %h need %h", i, f_data[i], want[i]); end
    end
    vectors++; if (ovf_count !== 16'd2) begin miscompares++; $display("FAIL sat_ovf: got %0d need 2", ovf_count); end
  endtask

  task automatic test_full();
    bit seen_full;
    seen_full = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (!in_ready && !seen_full) begin
        seen_full = 1'b1;
        vectors++; if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_level: got %0d need 16", fifo_level); end
      end
      offer(16'($urandom));
    end
    vectors++; if (!seen_full) begin miscompares++; $display("FAIL full_ready: in_ready got 1 need 0 at some point"); end
    vectors++; if (drop_count < 8'd3 || drop_count > 8'd4) begin miscompares++; $display("FAIL full_drop_range: got %0d need 3..4", drop_count); end
    vectors++; if (int'(drop_count) != exp_drop) begin miscompares++; $display("FAIL full_drop: got %0d need %0d", drop_count, exp_drop); end
    wait_frames(exp_q.size(), 20 * 70 + 100);
    for (int i = 0; i < exp_q.size() && i < f_data.size(); i++) begin
      vectors++; if (f_data[i] !== exp_q[i]) begin miscompares++; $display("FAIL full_order[%0d]: got %h need %h", i, f_data[i], exp_q[i]); end
    end
    repeat (10) @(negedge clk);
    vectors++; if (f_data.size() != exp_q.size()) begin miscompares++; $display("FAIL full_count: got %0d frames need %0d", f_data.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    offer(16'($urandom)); offer(16'($urandom));
    wait_frames(2, 300);
    if (f_data.size() >= 2) begin
      vectors++; if (f_start[1] - f_start[0] != 69) begin miscompares++; $display("FAIL b2b_period: got %0d need 69", f_start[1] - f_start[0]); end
      vectors++; if (f_start[1] - f_end[0] != 5) begin miscompares++; $display("FAIL b2b_gap: got %0d need 5", f_start[1] - f_end[0]); end
      for (int i = 0; i < 2; i++) begin
        vectors++; if (f_data[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h need %h", i, f_data[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, low_before;
    do_reset();
    for (int i = 0; i < 5; i++) offer(16'($urandom));
    t = 0;
    while (dac_cs_n && t < 20) begin @(negedge clk); t++; end
    vectors++; if (dac_cs_n !== 1'b0) begin miscompares++; $display("FAIL midrst_start: cs_n got %b need 0", dac_cs_n); end
    repeat (27) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (dac_cs_n !== 1'b1) begin miscompares++; $display("FAIL midrst_cs_n: got %b need 1", dac_cs_n); end
    vectors++; if (dac_sclk !== 1'b0) begin miscompares++; $display("FAIL midrst_sclk: got %b need 0", dac_sclk); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL midrst_level: got %0d need 0", fifo_level); end
    low_before = cs_low_total;
    repeat (200) @(negedge clk);
    vectors++; if (cs_low_total != low_before) begin miscompares++; $display("FAIL midrst_quiet: cs_n low %0d cycles need 0", cs_low_total - low_before); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       v = 16'($urandom_range(0, 32767)) - 16'd16384;
          1:       v = 16'($urandom_range(16200, 16400));
          default: v = 16'($urandom);
        endcase
        offer(v);
      end else begin
        @(negedge clk);
      end
    end
    wait_frames(exp_q.size(), 20 * 70 + 100);
    for (int i = 0; i < exp_q.size() && i < f_data.size(); i++) begin
      vectors++; if (f_data[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_data[%0d]: got %h need %h", i, f_data[i], exp_q[i]); end
    end
    vectors++; if (int'(ovf_count) != exp_ovf) begin miscompares++; $display("FAIL rand_ovf: got %0d need %0d", ovf_count, exp_ovf); end
    vectors++; if (int'(drop_count) != exp_drop) begin miscompares++; $display("FAIL rand_drop: got %0d need %0d", drop_count, exp_drop); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL rand_drain: level %0d need 0", fifo_level); end
  endtask

  // Scenario sequence.
  initial begin
    clear_model();
    test_reset();
    test_rounding();
    test_saturation();
    test_full();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_serializer.md
Name: dac_serializer

Overview:
- Output stage directly downstream of the 8-bit-in/16-bit-out audio filter core.
- Accepts the filter's signed 16-bit result `y` with a valid/ready handshake, then rounds and saturates it to signed 8 bits.
- Buffers results in a small FIFO and shifts each sample out MSB-first on a 3-wire serial DAC interface (sclk/sdata/cs_n).
- Counts saturation events and dropped samples for the bench and debug.

Parameters:
- IN_W, 16, input sample width (signed two's complement).
- OUT_W, 8, output sample width (signed two's complement).
- SHIFT, 7, right-shift applied after rounding.
- DEPTH, 16, FIFO depth in samples (power of 2).
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- y_in  in  16  filter output sample, signed.
- y_valid  in  1  y_in valid this cycle.
- in_ready  out  1  FIFO can accept a sample this cycle.
- dac_sclk  out  1  serial clock to DAC.
- dac_sdata  out  1  serial data, MSB first.
- dac_cs_n  out  1  frame select, active-low.
- fifo_level  out  5  samples currently stored (0..DEPTH).
- ovf_count  out  16  saturation events, sticks at 0xFFFF.
- drop_count  out  8  samples offered while full, sticks at 0xFF.

Behaviour:
- Decided: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - in_ready=1, dac_sclk=0, dac_sdata=0, dac_cs_n=1.
  - fifo_level=0, ovf_count=0, drop_count=0.
  - FIFO pointers 0; FSM in IDLE.
  - A reset mid-frame aborts the frame at the next edge (cs_n high) and discards the FIFO contents.
- Quantisation (combinational, before the FIFO):
  - s = (sign-extend y_in to 17 bits) + 2^(SHIFT-1).
  - q = s >>> SHIFT (arithmetic shift).
  - If q > 127, store 0x7F; if q < -128, store 0x80. Either case increments ovf_count.
  - Otherwise store q[7:0].
- Handshake and FIFO:
  - in_ready = (fifo_level != DEPTH), derived from registered state.
  - A push occurs when y_valid && in_ready.
  - y_valid && !in_ready drops the sample and increments drop_count. A dropped sample does not touch ovf_count.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is visible to the FSM the cycle after.
- FSM states:
  - IDLE: if fifo_level != 0, at the next edge:
    - pop the head into an 8-bit shift register; drive dac_sdata = head[7];
    - set dac_cs_n=0, dac_sclk=0, div_cnt=0, bit_cnt=0; go to SHIFT.
    - If the FIFO is empty, stay in IDLE with cs_n=1 and sclk=0.
  - SHIFT:
    - div_cnt counts 0..2*CLK_DIV-1.
    - dac_sclk is registered: high when div_cnt is in CLK_DIV..2*CLK_DIV-1, otherwise low. The DAC samples on the sclk rising edge.
    - On div_cnt wrap: bit_cnt++, shift left, and dac_sdata takes the next bit, changing with the sclk falling edge.
    - After the wrap of bit 7, go to GAP with dac_cs_n=1, dac_sclk=0, dac_sdata=0.
  - GAP: hold for CLK_DIV cycles, then go to IDLE.
- Timing (default CLK_DIV=4):
  - Frame cycle: 1 pop cycle + 16*CLK_DIV shift cycles + CLK_DIV gap cycles = 69 clk.
  - cs_n is low for exactly 64 cycles; sclk gives exactly 8 rising edges per frame.
- Back-to-back frames: IDLE always costs one cycle, so the minimum cs_n-high time between frames is CLK_DIV+1 cycles.
- fifo_level updates on the edge of the push or pop.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 3 cycles with y_valid=1.
  - Response: no push; in_ready=1; cs_n=1; sclk=0; all counts 0.
- Rounding:
  - Stimulus: push 0x1234, 0xFFC0, 0xFFBF.
  - Response: serial frames 0x24, 0x00, 0xFF, each MSB first, with 8 sclk rising edges and cs_n low for 64 cycles; ovf_count=0.
- Saturation:
  - Stimulus: push 0x7FFF then 0x8000.
  - Response: frames 0x7F then 0x80; ovf_count=2.
- Full FIFO:
  - Stimulus: assert y_valid with a new sample every cycle for 20 cycles from empty.
  - Response: in_ready falls once fifo_level reaches 16; drop_count=3 or 4, exact per pop timing (bench checks pushes + drops = 20); samples are later serialised in push order with none missing or duplicated.
- Back-to-back:
  - Stimulus: preload 2 samples.
  - Response: cs_n-high gap between frames is 5 cycles; frame start-to-start is 69 cycles.
- Reset mid-frame:
  - Stimulus: assert rst during bit 3 of a frame with 5 samples queued.
  - Response: next cycle cs_n=1, sclk=0, fifo_level=0; no further frame until a new push.
